// File: rtl/dpram_port_arbiter_if.sv
// Requester/RAM bundle between the dual-port RAM arbiter and its neighbours.
// The arbiter uses the slave modport; requesters plus the RAM model sit on master.
interface dpram_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] rsp_rdata;
  logic                      we_a, we_b;
  logic [ADDR_W-1:0]         addr_a, addr_b;
  logic [DATA_W-1:0]         data_a, data_b;
  logic [DATA_W-1:0]         q_a, q_b;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, q_a, q_b,
    output req_ready, rsp_valid, rsp_rdata, we_a, we_b, addr_a, addr_b, data_a, data_b
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, q_a, q_b,
    input  req_ready, rsp_valid, rsp_rdata, we_a, we_b, addr_a, addr_b, data_a, data_b
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a synchronous dual-port RAM among NUM_REQ requesters.
// Optional `DPRAM_ARB_COLL_CNT_EN adds a saturating count of collision-withheld second grants.
module dpram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dpram_port_arbiter_if.slave  bus
`ifdef DPRAM_ARB_COLL_CNT_EN
  ,
  output logic [15:0]          coll_cnt
`endif
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      pend_a_vld_q, pend_a_vld_d, pend_b_vld_q, pend_b_vld_d;
  logic [IDX_W-1:0]          pend_a_id_q, pend_a_id_d, pend_b_id_q, pend_b_id_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic             ga_vld, gb_vld, ga_act, gb_act, coll;
  logic [IDX_W-1:0] ga_id, gb_id;
  logic [ADDR_W-1:0] ga_addr, gb_addr;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // First two valid requesters, scanning upward from rr_ptr with wrap.
  always_comb begin
    int idx;
    idx    = 0;
    ga_vld = 1'b0;
    gb_vld = 1'b0;
    ga_id  = '0;
    gb_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx]) begin
        if (!ga_vld) begin
          ga_vld = 1'b1;
          ga_id  = IDX_W'(idx);
        end else if (!gb_vld) begin
          gb_vld = 1'b1;
          gb_id  = IDX_W'(idx);
        end
      end
    end
  end

  assign ga_addr = bus.req_addr[int'(ga_id)*ADDR_W +: ADDR_W];
  assign gb_addr = bus.req_addr[int'(gb_id)*ADDR_W +: ADDR_W];
  // Same address with any write: second grant waits; two reads may share.
  assign coll    = ga_vld && gb_vld && (ga_addr == gb_addr) &&
                   (bus.req_we[ga_id] || bus.req_we[gb_id]);
  assign ga_act  = ga_vld && !rst;
  assign gb_act  = gb_vld && !coll && !rst;

  assign bus.we_a   = ga_act && bus.req_we[ga_id];
  assign bus.addr_a = ga_act ? ga_addr : '0;
  assign bus.data_a = ga_act ? bus.req_wdata[int'(ga_id)*DATA_W +: DATA_W] : '0;
  assign bus.we_b   = gb_act && bus.req_we[gb_id];
  assign bus.addr_b = gb_act ? gb_addr : '0;
  assign bus.data_b = gb_act ? bus.req_wdata[int'(gb_id)*DATA_W +: DATA_W] : '0;

  always_comb begin
    bus.req_ready = '0;
    if (ga_act) bus.req_ready[ga_id] = 1'b1;
    if (gb_act) bus.req_ready[gb_id] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gb_act)      rr_ptr_d = next_idx(gb_id);
    else if (ga_act) rr_ptr_d = next_idx(ga_id);

    pend_a_vld_d = ga_act && !bus.req_we[ga_id];
    pend_a_id_d  = ga_id;
    pend_b_vld_d = gb_act && !bus.req_we[gb_id];
    pend_b_id_d  = gb_id;

    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (pend_a_vld_q) begin
      rsp_valid_d[pend_a_id_q] = 1'b1;
      rsp_rdata_d[int'(pend_a_id_q)*DATA_W +: DATA_W] = bus.q_a;
    end
    if (pend_b_vld_q) begin
      rsp_valid_d[pend_b_id_q] = 1'b1;
      rsp_rdata_d[int'(pend_b_id_q)*DATA_W +: DATA_W] = bus.q_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      pend_a_vld_q <= 1'b0;
      pend_a_id_q  <= '0;
      pend_b_vld_q <= 1'b0;
      pend_b_id_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pend_a_vld_q <= pend_a_vld_d;
      pend_a_id_q  <= pend_a_id_d;
      pend_b_vld_q <= pend_b_vld_d;
      pend_b_id_q  <= pend_b_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DPRAM_ARB_COLL_CNT_EN
  logic [15:0] coll_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 coll_cnt_q <= '0;
    else if (coll && coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
  end

  assign coll_cnt = coll_cnt_q;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural 64x8 dual-port RAM attached.
module tb_dpram_port_arbiter;
  logic clk;
  logic rst;
  logic init_mem;
  int   n_total;
  int   n_bad;
  logic [7:0] mem [64];

  dpram_port_arbiter_if #(.NUM_REQ(4), .ADDR_W(6), .DATA_W(8)) bus ();

`ifdef DPRAM_ARB_COLL_CNT_EN
  logic [15:0] coll_cnt;
`endif

  dpram_port_arbiter #(.NUM_REQ(4), .ADDR_W(6), .DATA_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DPRAM_ARB_COLL_CNT_EN
    ,
    .coll_cnt (coll_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, one-cycle latency; preload mem[i] = i + 0x30.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i) + 8'h30;
    end else begin
      if (bus.we_a) mem[bus.addr_a] <= bus.data_a;
      if (bus.we_b) mem[bus.addr_b] <= bus.data_b;
    end
    bus.q_a <= mem[bus.addr_a];
    bus.q_b <= mem[bus.addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [5:0] addr, input logic [7:0] wd);
    bus.req_valid[i]        = 1'b1;
    bus.req_we[i]           = we;
    bus.req_addr[i*6 +: 6]  = addr;
    bus.req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic clr_reqs();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst      = 1'b1;
    init_mem = 1'b1;
    clr_reqs();
    bus.req_valid = 4'hF;
    tick();
    tick();
    init_mem = 1'b0;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_we_a", 32'(bus.we_a), 32'h0);
    chk("rst_we_b", 32'(bus.we_b), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    clr_reqs();
    rst = 1'b0;
    #1;

    // single write then read by req1
    set_req(1, 1'b1, 6'd45, 8'hB6);
    #1;
    chk("wr_ready", 32'(bus.req_ready), 32'h2);
    chk("wr_we_a", 32'(bus.we_a), 32'h1);
    chk("wr_addr_a", 32'(bus.addr_a), 32'd45);
    chk("wr_data_a", 32'(bus.data_a), 32'hB6);
    chk("wr_we_b", 32'(bus.we_b), 32'h0);
    tick();
    clr_reqs();
    set_req(1, 1'b0, 6'd45, 8'h00);
    #1;
    chk("rd_ready", 32'(bus.req_ready), 32'h2);
    chk("rd_we_a", 32'(bus.we_a), 32'h0);
    chk("rd_addr_a", 32'(bus.addr_a), 32'd45);
    tick();
    clr_reqs();
    #1;
    chk("rd_no_early_rsp", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("rd_rdata1", 32'(bus.rsp_rdata[15:8]), 32'hB6);

    // req3 alone moves rr_ptr back to 0
    set_req(3, 1'b1, 6'd63, 8'h11);
    #1;
    chk("align1_ready", 32'(bus.req_ready), 32'h8);
    tick();
    chk("rsp_pulse_end", 32'(bus.rsp_valid), 32'h0);
    chk("rdata1_hold", 32'(bus.rsp_rdata[15:8]), 32'hB6);

    // dual grant: req0 read @7 on A, req2 write @56 on B
    clr_reqs();
    set_req(0, 1'b0, 6'd7, 8'h00);
    set_req(2, 1'b1, 6'd56, 8'h0F);
    #1;
    chk("dual_ready", 32'(bus.req_ready), 32'h5);
    chk("dual_we_a", 32'(bus.we_a), 32'h0);
    chk("dual_addr_a", 32'(bus.addr_a), 32'd7);
    chk("dual_we_b", 32'(bus.we_b), 32'h1);
    chk("dual_addr_b", 32'(bus.addr_b), 32'd56);
    chk("dual_data_b", 32'(bus.data_b), 32'h0F);
    tick();
    // rr_ptr should now be 3: req3 wins port A over req0
    clr_reqs();
    set_req(0, 1'b0, 6'd2, 8'h00);
    set_req(3, 1'b0, 6'd1, 8'h00);
    #1;
    chk("rr3_ready", 32'(bus.req_ready), 32'h9);
    chk("rr3_addr_a", 32'(bus.addr_a), 32'd1);
    chk("rr3_addr_b", 32'(bus.addr_b), 32'd2);
    tick();
    chk("dual_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("dual_rdata0", 32'(bus.rsp_rdata[7:0]), 32'h37);

    // rr_ptr = 1 here; req3 alone returns it to 0
    clr_reqs();
    set_req(3, 1'b1, 6'd63, 8'h22);
    #1;
    chk("align2_ready", 32'(bus.req_ready), 32'h8);
    tick();
    chk("rr3_rsp_valid", 32'(bus.rsp_valid), 32'h9);
    chk("rr3_rdata3", 32'(bus.rsp_rdata[31:24]), 32'h31);
    chk("rr3_rdata0", 32'(bus.rsp_rdata[7:0]), 32'h32);

    // collision: req0 writes 55 @45, req1 reads @45
    clr_reqs();
    set_req(0, 1'b1, 6'd45, 8'd55);
    set_req(1, 1'b0, 6'd45, 8'h00);
    #1;
    chk("coll_ready", 32'(bus.req_ready), 32'h1);
    chk("coll_we_a", 32'(bus.we_a), 32'h1);
    chk("coll_addr_a", 32'(bus.addr_a), 32'd45);
    chk("coll_data_a", 32'(bus.data_a), 32'd55);
    chk("coll_we_b", 32'(bus.we_b), 32'h0);
    chk("coll_addr_b", 32'(bus.addr_b), 32'h0);
    tick();
    clr_reqs();
    set_req(1, 1'b0, 6'd45, 8'h00);
    #1;
    chk("coll_retry_ready", 32'(bus.req_ready), 32'h2);
    chk("coll_retry_addr_a", 32'(bus.addr_a), 32'd45);
    tick();
    clr_reqs();
    #1;
    tick();
    chk("coll_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("coll_rdata1", 32'(bus.rsp_rdata[15:8]), 32'd55);
`ifdef DPRAM_ARB_COLL_CNT_EN
    chk("coll_cnt_one", 32'(coll_cnt), 32'd1);
`endif

    // rr_ptr = 2 here; req3 alone returns it to 0
    set_req(3, 1'b1, 6'd63, 8'h33);
    #1;
    chk("align3_ready", 32'(bus.req_ready), 32'h8);
    tick();

    // fairness: four reads held for four cycles
    clr_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'(10 + i), 8'h00);
    #1;
    chk("fair_c1_ready", 32'(bus.req_ready), 32'h3);
    chk("fair_c1_addr_a", 32'(bus.addr_a), 32'd10);
    chk("fair_c1_addr_b", 32'(bus.addr_b), 32'd11);
    tick();
    chk("fair_c2_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("fair_c2_ready", 32'(bus.req_ready), 32'hC);
    chk("fair_c2_addr_a", 32'(bus.addr_a), 32'd12);
    chk("fair_c2_addr_b", 32'(bus.addr_b), 32'd13);
    tick();
    chk("fair_c3_rsp", 32'(bus.rsp_valid), 32'h3);
    chk("fair_rdata0", 32'(bus.rsp_rdata[7:0]), 32'h3A);
    chk("fair_rdata1", 32'(bus.rsp_rdata[15:8]), 32'h3B);
    chk("fair_c3_ready", 32'(bus.req_ready), 32'h3);
    tick();
    chk("fair_c4_rsp", 32'(bus.rsp_valid), 32'hC);
    chk("fair_rdata2", 32'(bus.rsp_rdata[23:16]), 32'h3C);
    chk("fair_rdata3", 32'(bus.rsp_rdata[31:24]), 32'h3D);
    chk("fair_c4_ready", 32'(bus.req_ready), 32'hC);
    tick();
    chk("fair_c5_rsp", 32'(bus.rsp_valid), 32'h3);
    clr_reqs();
    tick();
    chk("fair_c6_rsp", 32'(bus.rsp_valid), 32'hC);

    // same-address reads of 0xCC @42
    set_req(0, 1'b1, 6'd42, 8'hCC);
    #1;
    chk("cc_wr_ready", 32'(bus.req_ready), 32'h1);
    tick();
    clr_reqs();
    set_req(2, 1'b0, 6'd42, 8'h00);
    set_req(3, 1'b0, 6'd42, 8'h00);
    #1;
    chk("same_ready", 32'(bus.req_ready), 32'hC);
    chk("same_addr_a", 32'(bus.addr_a), 32'd42);
    chk("same_addr_b", 32'(bus.addr_b), 32'd42);
    chk("same_we_a", 32'(bus.we_a), 32'h0);
    chk("same_we_b", 32'(bus.we_b), 32'h0);
    tick();
    clr_reqs();
    #1;
    tick();
    chk("same_rsp_valid", 32'(bus.rsp_valid), 32'hC);
    chk("same_rdata2", 32'(bus.rsp_rdata[23:16]), 32'hCC);
    chk("same_rdata3", 32'(bus.rsp_rdata[31:24]), 32'hCC);
`ifdef DPRAM_ARB_COLL_CNT_EN
    chk("coll_cnt_same", 32'(coll_cnt), 32'd1);
`endif

    // reset mid-run with req1's read in flight (rr_ptr would be 2)
    set_req(1, 1'b0, 6'd10, 8'h00);
    #1;
    chk("pre_rst_ready", 32'(bus.req_ready), 32'h2);
    tick();
    rst = 1'b1;
    clr_reqs();
    set_req(0, 1'b0, 6'd2, 8'h00);
    set_req(3, 1'b0, 6'd5, 8'h00);
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    chk("mid_rst_we_a", 32'(bus.we_a), 32'h0);
    chk("mid_rst_we_b", 32'(bus.we_b), 32'h0);
    chk("mid_rst_addr_a", 32'(bus.addr_a), 32'h0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_rdata1", 32'(bus.rsp_rdata[15:8]), 32'h0);
    tick();
    chk("rst_edge_rsp", 32'(bus.rsp_valid), 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'h9);
    chk("post_rst_addr_a", 32'(bus.addr_a), 32'd2);
    chk("post_rst_addr_b", 32'(bus.addr_b), 32'd5);
`ifdef DPRAM_ARB_COLL_CNT_EN
    chk("coll_cnt_rst", 32'(coll_cnt), 32'd0);
`endif
    tick();
    clr_reqs();
    #1;
    chk("dropped_rsp", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("post_rst_rsp", 32'(bus.rsp_valid), 32'h9);
    chk("post_rst_rdata0", 32'(bus.rsp_rdata[7:0]), 32'h32);
    chk("post_rst_rdata3", 32'(bus.rsp_rdata[31:24]), 32'h35);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
